rv32_barrel_wb_arbiter: RTL and testbench

- Write-side front end of the barrel register file: merges execute-stage results and late load responses onto the single regfile write port (rd_hart/wen/wa/wd).
- Execute writebacks always win, because the barrel pipeline cannot stall. Load responses are queued in a FIFO and drained into idle write slots.
- Keeps a per-hart load-pending scoreboard so the hart scheduler can hold a hart until its load data has been written.

---
 rtl/rv32_barrel_pkg.sv | 27 ++
 rtl/rv32_barrel_wb_arbiter_chk.sv | 25 ++
 rtl/rv32_wb_fifo.sv | 64 ++++++
 rtl/rv32_barrel_wb_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rv32_barrel_wb_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_barrel_pkg.sv
// Shared types for the barrel-pipeline writeback front end.
// Supplies default widths when the core-wide register/XLEN defines are absent.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

package rv32_barrel_pkg;

    localparam int NUM_HARTS_DEFAULT     = 8;
    localparam int LD_FIFO_DEPTH_DEFAULT = 4;
    // Hart field is sized for the largest supported barrel; narrower configs zero-extend.
    localparam int WB_HART_W             = 8;

    typedef struct packed {
        logic [WB_HART_W-1:0]       hart;
        logic [`REG_ADDR_WIDTH-1:0] rd;
        logic [`XPR_LEN-1:0]        data;
    } wb_req_t;

    function automatic logic rd_is_live(input logic [`REG_ADDR_WIDTH-1:0] rd);
        return rd != {`REG_ADDR_WIDTH{1'b0}};
    endfunction

endpackage

// File: rtl/rv32_barrel_wb_arbiter_chk.sv
// Simulation checks for the writeback arbiter: double load issue per hart and hart-field range.
module rv32_barrel_wb_arbiter_chk
    import rv32_barrel_pkg::*;
#(
    parameter int NUM_HARTS      = NUM_HARTS_DEFAULT,
    parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS)
) (
    input logic                      clk,
    input logic                      rst_n,
    input logic                      ld_issue_valid,
    input logic [HART_CNT_WIDTH-1:0] ld_issue_hart,
    input logic [NUM_HARTS-1:0]      ld_busy,
    input logic                      head_valid,
    input logic [WB_HART_W-1:0]      head_hart
);

    // A hart must not issue a second load while its first is still outstanding.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(ld_issue_valid && ld_busy[ld_issue_hart]));
            assert (!head_valid || ((head_hart >> HART_CNT_WIDTH) == {WB_HART_W{1'b0}}));
        end
    end

endmodule

// File: rtl/rv32_wb_fifo.sv
// Circular queue of pending load writebacks; head entry is visible while not empty.
module rv32_wb_fifo
    import rv32_barrel_pkg::*;
#(
    parameter int DEPTH = LD_FIFO_DEPTH_DEFAULT
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  wb_req_t push_data_i,
    input  logic    pop_i,
    output wb_req_t pop_data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign empty_o    = (cnt_q == {CNT_W{1'b0}});
    assign push_ok_s  = push_i && !full_o;
    assign pop_ok_s   = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = push_ok_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/rv32_barrel_wb_arbiter.sv
// Regfile write-port arbiter: exec results take priority, queued load responses fill idle slots.
// Optional build macro RV32_WB_STATS_EN adds commit/stall counters.
module rv32_barrel_wb_arbiter
    import rv32_barrel_pkg::*;
#(
    parameter int NUM_HARTS      = NUM_HARTS_DEFAULT,
    parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS),
    parameter int LD_FIFO_DEPTH  = LD_FIFO_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       exec_valid,
    input  logic [HART_CNT_WIDTH-1:0]  exec_hart,
    input  logic [`REG_ADDR_WIDTH-1:0] exec_rd,
    input  logic [`XPR_LEN-1:0]        exec_data,
    input  logic                       ld_issue_valid,
    input  logic [HART_CNT_WIDTH-1:0]  ld_issue_hart,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [HART_CNT_WIDTH-1:0]  ld_hart,
    input  logic [`REG_ADDR_WIDTH-1:0] ld_rd,
    input  logic [`XPR_LEN-1:0]        ld_data,
    output logic [NUM_HARTS-1:0]       ld_busy,
    output logic [HART_CNT_WIDTH-1:0]  rd_hart,
    output logic                       wen,
    output logic [`REG_ADDR_WIDTH-1:0] wa,
    output logic [`XPR_LEN-1:0]        wd
`ifdef RV32_WB_STATS_EN
    ,
    output logic [31:0]                stat_exec_wr,
    output logic [31:0]                stat_ld_wr,
    output logic [31:0]                stat_ld_stall
`endif
);

    logic                       wen_q, wen_d;
    logic [HART_CNT_WIDTH-1:0]  rd_hart_q, rd_hart_d;
    logic [`REG_ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [`XPR_LEN-1:0]        wd_q, wd_d;
    logic [NUM_HARTS-1:0]       busy_q, busy_d;

    logic                       exec_wr_s;
    logic                       ld_accept_s;
    logic                       ld_push_s;
    logic                       ld_drop_s;
    logic                       ld_pop_s;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    wb_req_t                    push_req_s;
    wb_req_t                    head_s;
    logic [HART_CNT_WIDTH-1:0]  head_hart_s;

    assign exec_wr_s   = exec_valid && rd_is_live(exec_rd);
    assign ld_ready    = !fifo_full_s;
    assign ld_accept_s = ld_valid && ld_ready;
    assign ld_push_s   = ld_accept_s && rd_is_live(ld_rd);
    assign ld_drop_s   = ld_accept_s && !rd_is_live(ld_rd);
    // The pipeline cannot stall, so the queue only drains when exec leaves the slot empty.
    assign ld_pop_s    = !exec_wr_s && !fifo_empty_s;
    assign head_hart_s = head_s.hart[HART_CNT_WIDTH-1:0];

    assign push_req_s.hart = WB_HART_W'(ld_hart);
    assign push_req_s.rd   = ld_rd;
    assign push_req_s.data = ld_data;

    rv32_wb_fifo #(
        .DEPTH (LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ld_push_s),
        .push_data_i (push_req_s),
        .pop_i       (ld_pop_s),
        .pop_data_o  (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Write-slot selection: exec first, then FIFO head, else idle.
    always_comb begin
        wen_d     = 1'b0;
        rd_hart_d = {HART_CNT_WIDTH{1'b0}};
        wa_d      = {`REG_ADDR_WIDTH{1'b0}};
        wd_d      = {`XPR_LEN{1'b0}};
        if (exec_wr_s) begin
            wen_d     = 1'b1;
            rd_hart_d = exec_hart;
            wa_d      = exec_rd;
            wd_d      = exec_data;
        end else if (ld_pop_s) begin
            wen_d     = 1'b1;
            rd_hart_d = head_hart_s;
            wa_d      = head_s.rd;
            wd_d      = head_s.data;
        end else begin
            wen_d     = 1'b0;
        end
    end

    // Load-pending scoreboard; a same-cycle issue overrides any clear for that hart.
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            busy_d[h] = (ld_issue_valid && (ld_issue_hart == HART_CNT_WIDTH'(h)))
                     || (busy_q[h]
                         && !(ld_pop_s  && (head_hart_s == HART_CNT_WIDTH'(h)))
                         && !(ld_drop_s && (ld_hart     == HART_CNT_WIDTH'(h))));
        end
    end

    // Registered write port and scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q     <= 1'b0;
            rd_hart_q <= {HART_CNT_WIDTH{1'b0}};
            wa_q      <= {`REG_ADDR_WIDTH{1'b0}};
            wd_q      <= {`XPR_LEN{1'b0}};
            busy_q    <= {NUM_HARTS{1'b0}};
        end else begin
            wen_q     <= wen_d;
            rd_hart_q <= rd_hart_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            busy_q    <= busy_d;
        end
    end

    assign wen     = wen_q;
    assign rd_hart = rd_hart_q;
    assign wa      = wa_q;
    assign wd      = wd_q;
    assign ld_busy = busy_q;

`ifdef RV32_WB_STATS_EN
    logic [31:0] stat_exec_wr_q;
    logic [31:0] stat_ld_wr_q;
    logic [31:0] stat_ld_stall_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_exec_wr_q  <= 32'd0;
            stat_ld_wr_q    <= 32'd0;
            stat_ld_stall_q <= 32'd0;
        end else begin
            stat_exec_wr_q  <= stat_exec_wr_q  + {31'd0, exec_wr_s};
            stat_ld_wr_q    <= stat_ld_wr_q    + {31'd0, ld_pop_s};
            stat_ld_stall_q <= stat_ld_stall_q + {31'd0, (ld_valid && !ld_ready)};
        end
    end

    assign stat_exec_wr  = stat_exec_wr_q;
    assign stat_ld_wr    = stat_ld_wr_q;
    assign stat_ld_stall = stat_ld_stall_q;
`endif

    rv32_barrel_wb_arbiter_chk #(
        .NUM_HARTS      (NUM_HARTS),
        .HART_CNT_WIDTH (HART_CNT_WIDTH)
    ) u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_hart  (ld_issue_hart),
        .ld_busy        (busy_q),
        .head_valid     (!fifo_empty_s),
        .head_hart      (head_s.hart)
    );

endmodule

// File: tb/tb_rv32_barrel_wb_arbiter.sv
// Directed self-checking bench for rv32_barrel_wb_arbiter (8 harts, 4-entry load queue).
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module tb_rv32_barrel_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exec_valid;
    logic [2:0]  exec_hart;
    logic [4:0]  exec_rd;
    logic [31:0] exec_data;
    logic        ld_issue_valid;
    logic [2:0]  ld_issue_hart;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_hart;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [7:0]  ld_busy;
    logic [2:0]  rd_hart;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
`ifdef RV32_WB_STATS_EN
    logic [31:0] stat_exec_wr;
    logic [31:0] stat_ld_wr;
    logic [31:0] stat_ld_stall;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32_barrel_wb_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exec_valid     (exec_valid),
        .exec_hart      (exec_hart),
        .exec_rd        (exec_rd),
        .exec_data      (exec_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_hart  (ld_issue_hart),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_hart        (ld_hart),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
        .ld_busy        (ld_busy),
        .rd_hart        (rd_hart),
        .wen            (wen),
        .wa             (wa),
        .wd             (wd)
`ifdef RV32_WB_STATS_EN
        ,
        .stat_exec_wr   (stat_exec_wr),
        .stat_ld_wr     (stat_ld_wr),
        .stat_ld_stall  (stat_ld_stall)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exec_valid     = 1'b0;
        exec_hart      = 3'd0;
        exec_rd        = 5'd0;
        exec_data      = 32'd0;
        ld_issue_valid = 1'b0;
        ld_issue_hart  = 3'd0;
        ld_valid       = 1'b0;
        ld_hart        = 3'd0;
        ld_rd          = 5'd0;
        ld_data        = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL reset_wen: got %0h want 0", wen); end
        n_cmp++; if (wa !== 5'd0) begin n_bad++; $display("FAIL reset_wa: got %0h want 0", wa); end
        n_cmp++; if (wd !== 32'd0) begin n_bad++; $display("FAIL reset_wd: got %0h want 0", wd); end
        n_cmp++; if (rd_hart !== 3'd0) begin n_bad++; $display("FAIL reset_rd_hart: got %0h want 0", rd_hart); end
        n_cmp++; if (ld_busy !== 8'h00) begin n_bad++; $display("FAIL reset_busy: got %0h want 0", ld_busy); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0h want 1", ld_ready); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_exec();
        exec_valid = 1'b1; exec_hart = 3'd3; exec_rd = 5'd5; exec_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        n_cmp++; if (wen !== 1'b1) begin n_bad++; $display("FAIL exec_wen: got %0h want 1", wen); end
        n_cmp++; if (rd_hart !== 3'd3) begin n_bad++; $display("FAIL exec_hart: got %0h want 3", rd_hart); end
        n_cmp++; if (wa !== 5'd5) begin n_bad++; $display("FAIL exec_wa: got %0h want 5", wa); end
        n_cmp++; if (wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL exec_wd: got %0h want deadbeef", wd); end
        step();
        n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL exec_wen_after: got %0h want 0", wen); end
    endtask

    task automatic test_load_latency();
        ld_issue_valid = 1'b1; ld_issue_hart = 3'd2;
        step();
        idle_inputs();
        n_cmp++; if (ld_busy !== 8'h04) begin n_bad++; $display("FAIL ld_busy_set: got %0h want 04", ld_busy); end
        step();
        step();
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL ld_ready_idle: got %0h want 1", ld_ready); end
        ld_valid = 1'b1; ld_hart = 3'd2; ld_rd = 5'd7; ld_data = 32'h1234;
        step();
        idle_inputs();
        n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL ld_lat_n1_wen: got %0h want 0", wen); end
        n_cmp++; if (ld_busy !== 8'h04) begin n_bad++; $display("FAIL ld_busy_held: got %0h want 04", ld_busy); end
        step();
        n_cmp++; if (wen !== 1'b1) begin n_bad++; $display("FAIL ld_lat_wen: got %0h want 1", wen); end
        n_cmp++; if (wa !== 5'd7) begin n_bad++; $display("FAIL ld_lat_wa: got %0h want 7", wa); end
        n_cmp++; if (wd !== 32'h1234) begin n_bad++; $display("FAIL ld_lat_wd: got %0h want 1234", wd); end
        n_cmp++; if (rd_hart !== 3'd2) begin n_bad++; $display("FAIL ld_lat_hart: got %0h want 2", rd_hart); end
        n_cmp++; if (ld_busy !== 8'h00) begin n_bad++; $display("FAIL ld_busy_clr: got %0h want 00", ld_busy); end
        step();
        n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL ld_lat_idle: got %0h want 0", wen); end
    endtask

    task automatic test_exec_burst();
        for (int i = 0; i < 8; i++) begin
            exec_valid = 1'b1; exec_hart = 3'(i); exec_rd = 5'(i + 1); exec_data = 32'(i) + 32'h100;
            if (i == 0) begin
                ld_valid = 1'b1; ld_hart = 3'd4; ld_rd = 5'd9; ld_data = 32'hAAAA;
            end
            step();
            ld_valid = 1'b0;
            n_cmp++;
            if (wen !== 1'b1 || wa !== 5'(i + 1) || wd !== 32'(i) + 32'h100) begin
                n_bad++;
                $display("FAIL burst_exec[%0d]: got wen=%0h wa=%0h wd=%0h want 1/%0h/%0h", i, wen, wa, wd, i + 1, i + 256);
            end
        end
        idle_inputs();
        step();
        n_cmp++;
        if (wen !== 1'b1 || wa !== 5'd9 || wd !== 32'hAAAA || rd_hart !== 3'd4) begin
            n_bad++;
            $display("FAIL burst_load: got wen=%0h wa=%0h wd=%0h hart=%0h want 1/9/aaaa/4", wen, wa, wd, rd_hart);
        end
        step();
        n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL burst_idle: got %0h want 0", wen); end
    endtask

    task automatic test_fifo_full();
        exec_valid = 1'b1; exec_hart = 3'd0; exec_rd = 5'd1; exec_data = 32'h0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready[%0d]: got %0h want 1", k, ld_ready); end
            ld_valid = 1'b1; ld_hart = 3'(k); ld_rd = 5'(10 + k); ld_data = 32'h100 + 32'(k);
            step();
        end
        ld_valid = 1'b1; ld_hart = 3'd4; ld_rd = 5'd14; ld_data = 32'h104;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL full_stall[%0d]: got %0h want 0", k, ld_ready); end
            if (k < 3) step();
        end
        exec_valid = 1'b0; exec_rd = 5'd0;
        step();
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL full_reopen: got %0h want 1", ld_ready); end
        for (int j = 0; j < 5; j++) begin
            if (j > 0) step();
            if (j == 1) ld_valid = 1'b0;
            n_cmp++;
            if (wen !== 1'b1 || wa !== 5'(10 + j) || wd !== 32'h100 + 32'(j) || rd_hart !== 3'(j)) begin
                n_bad++;
                $display("FAIL full_drain[%0d]: got wen=%0h wa=%0h wd=%0h hart=%0h want 1/%0h/%0h/%0h", j, wen, wa, wd, rd_hart, 10 + j, 256 + j, j);
            end
        end
        idle_inputs();
        step();
        n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL full_drained: got %0h want 0", wen); end
    endtask

    task automatic test_rd_zero();
        ld_issue_valid = 1'b1; ld_issue_hart = 3'd5;
        step();
        idle_inputs();
        n_cmp++; if (ld_busy !== 8'h20) begin n_bad++; $display("FAIL rd0_busy_set: got %0h want 20", ld_busy); end
        exec_valid = 1'b1; exec_hart = 3'd6; exec_rd = 5'd0; exec_data = 32'h5555;
        ld_valid = 1'b1; ld_hart = 3'd5; ld_rd = 5'd0; ld_data = 32'h7777;
        step();
        idle_inputs();
        n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL rd0_wen: got %0h want 0", wen); end
        n_cmp++; if (ld_busy !== 8'h00) begin n_bad++; $display("FAIL rd0_busy_clr: got %0h want 00", ld_busy); end
        step();
        n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL rd0_wen_late: got %0h want 0", wen); end
    endtask

    task automatic test_reset_mid();
        exec_valid = 1'b1; exec_hart = 3'd7; exec_rd = 5'd2; exec_data = 32'h99;
        for (int h = 1; h <= 3; h++) begin
            ld_issue_valid = 1'b1; ld_issue_hart = 3'(h);
            ld_valid = 1'b1; ld_hart = 3'(h); ld_rd = 5'(20 + h); ld_data = 32'(h);
            step();
        end
        n_cmp++; if (ld_busy !== 8'h0E) begin n_bad++; $display("FAIL rstmid_busy: got %0h want 0e", ld_busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL rstmid_wen: got %0h want 0", wen); end
        n_cmp++; if (ld_busy !== 8'h00) begin n_bad++; $display("FAIL rstmid_busy_clr: got %0h want 00", ld_busy); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %0h want 1", ld_ready); end
        idle_inputs();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale[%0d]: got %0h want 0", c, wen); end
        end
    endtask

    initial begin
        test_reset();
        test_exec();
        test_load_latency();
        test_exec_burst();
        test_fifo_full();
        test_rd_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
